// File: rtl/MD_pkg.sv
// Shared widths and state encoding for the position-ring injection controller.
package MD_pkg;

  localparam int GLOBAL_CELL_ID_WIDTH    = 5;
  localparam int OFFSET_PKT_STRUCT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } pos_inject_state_t;

endpackage

// File: rtl/pos_ring_inject_ctrl_credit_counter.sv
// Saturating up/down count of injected packets still on the ring, plus the credit flag.
module pos_inject_credit_counter #(
  parameter int MAX_INFLIGHT   = 32,
  parameter int INFLIGHT_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_inc,
  input  logic                      i_dec,
  output logic [INFLIGHT_WIDTH-1:0] o_count,
  output logic                      o_credit_ok
);

  localparam logic [INFLIGHT_WIDTH-1:0] MAX_CNT = INFLIGHT_WIDTH'(MAX_INFLIGHT);

  logic [INFLIGHT_WIDTH-1:0] count_q;
  logic                      dec_eff;

  // A retire with nothing outstanding is spurious and must not wrap the count.
  assign dec_eff = i_dec & (count_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (i_inc & ~dec_eff) begin
      count_q <= count_q + INFLIGHT_WIDTH'(1);
    end else if (dec_eff & ~i_inc) begin
      count_q <= count_q - INFLIGHT_WIDTH'(1);
    end
  end

  assign o_count     = count_q;
  assign o_credit_ok = (count_q < MAX_CNT);

endmodule

// File: rtl/pos_ring_inject_ctrl.sv
// Streams one home cell's particles from the position cache into the ring injection node.
// Optional stall-cycle counter port when POS_RING_INJECT_PERF_EN is defined.
//
// state  | meaning
// IDLE   | waiting for i_start
// STREAM | reading cache into holding buffer and injecting
// DRAIN  | all injected, waiting for every packet to retire
// DONE   | one-cycle o_done pulse
module pos_ring_inject_ctrl
  import MD_pkg::*;
#(
  parameter int PARTICLE_ADDR_WIDTH = 7,
  parameter int MAX_INFLIGHT        = 32,
  parameter int INFLIGHT_WIDTH      = 6
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_start,
  input  logic [PARTICLE_ADDR_WIDTH-1:0]      i_num_particles,
  input  logic [3*GLOBAL_CELL_ID_WIDTH-1:0]   i_gcid,
  output logic                                o_rd_en,
  output logic [PARTICLE_ADDR_WIDTH-1:0]      o_rd_addr,
  input  logic [OFFSET_PKT_STRUCT_WIDTH-1:0]  i_rd_data,
  input  logic                                i_slot_empty,
  input  logic                                i_dispatcher_back_pressure,
  input  logic                                i_retire,
  output logic [OFFSET_PKT_STRUCT_WIDTH-1:0]  o_local_offset_pkt,
  output logic [3*GLOBAL_CELL_ID_WIDTH-1:0]   o_local_gcid,
  output logic                                o_local_valid,
  output logic [INFLIGHT_WIDTH-1:0]           o_inflight,
  output logic                                o_busy,
  output logic                                o_done
`ifdef POS_RING_INJECT_PERF_EN
  ,
  output logic [15:0]                         o_stall_cycles
`endif
);

  localparam int AW = PARTICLE_ADDR_WIDTH;

  pos_inject_state_t state_q, state_d;

  logic [AW-1:0]                      num_q, rd_cnt_q, inject_cnt_q;
  logic                               rd_pending_q, buf_valid_q;
  logic [OFFSET_PKT_STRUCT_WIDTH-1:0] buf_data_q;
  logic [3*GLOBAL_CELL_ID_WIDTH-1:0]  gcid_q;
  logic                               credit_ok, inject, start_acc, last_inject;

  assign start_acc   = (state_q == IDLE) & i_start;
  assign inject      = buf_valid_q & i_slot_empty & ~i_dispatcher_back_pressure & credit_ok;
  assign last_inject = (({1'b0, inject_cnt_q} + {{AW{1'b0}}, inject}) == {1'b0, num_q});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    o_rd_en = 1'b0;
    o_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) state_d = (i_num_particles == '0) ? DONE : STREAM;
      end
      STREAM: begin
        // One read in flight at most; refill only when the buffer is free or draining now.
        o_rd_en = (rd_cnt_q < num_q) & ~rd_pending_q & (~buf_valid_q | inject);
        if (last_inject) state_d = DRAIN;
      end
      DRAIN: begin
        if ((o_inflight == '0) & ~i_retire) state_d = DONE;
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_q        <= '0;
      gcid_q       <= '0;
      rd_cnt_q     <= '0;
      inject_cnt_q <= '0;
      rd_pending_q <= 1'b0;
      buf_valid_q  <= 1'b0;
      buf_data_q   <= '0;
    end else begin
      rd_pending_q <= o_rd_en;
      if (start_acc) begin
        num_q        <= i_num_particles;
        gcid_q       <= i_gcid;
        rd_cnt_q     <= '0;
        inject_cnt_q <= '0;
        buf_valid_q  <= 1'b0;
      end else begin
        if (o_rd_en) rd_cnt_q <= rd_cnt_q + AW'(1);
        if (inject)  inject_cnt_q <= inject_cnt_q + AW'(1);
        if (rd_pending_q) begin
          buf_valid_q <= 1'b1;
          buf_data_q  <= i_rd_data;
        end else if (inject) begin
          buf_valid_q <= 1'b0;
        end
      end
    end
  end

  pos_inject_credit_counter #(
    .MAX_INFLIGHT  (MAX_INFLIGHT),
    .INFLIGHT_WIDTH(INFLIGHT_WIDTH)
  ) u_credit (
    .clk        (clk),
    .rst        (rst),
    .i_inc      (inject),
    .i_dec      (i_retire),
    .o_count    (o_inflight),
    .o_credit_ok(credit_ok)
  );

  assign o_rd_addr          = rd_cnt_q;
  assign o_local_valid      = inject;
  assign o_local_offset_pkt = buf_data_q;
  assign o_local_gcid       = gcid_q;
  assign o_busy             = (state_q != IDLE);

`ifdef POS_RING_INJECT_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
    end else if ((state_q == STREAM) & buf_valid_q & ~inject & (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign o_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pos_ring_inject_ctrl.sv
// Scoreboard bench for pos_ring_inject_ctrl: cache model, expected-packet queue, negedge monitor.
module tb_pos_ring_inject_ctrl;
  import MD_pkg::*;

  localparam int AW     = 7;
  localparam int TB_MAX = 4;
  localparam int IW     = 6;
  localparam int OW     = OFFSET_PKT_STRUCT_WIDTH;
  localparam int GW     = 3*GLOBAL_CELL_ID_WIDTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [AW-1:0] i_num_particles;
  logic [GW-1:0] i_gcid;
  logic          o_rd_en;
  logic [AW-1:0] o_rd_addr;
  logic [OW-1:0] i_rd_data;
  logic          i_slot_empty;
  logic          i_dispatcher_back_pressure;
  logic          i_retire;
  logic [OW-1:0] o_local_offset_pkt;
  logic [GW-1:0] o_local_gcid;
  logic          o_local_valid;
  logic [IW-1:0] o_inflight;
  logic          o_busy;
  logic          o_done;
`ifdef POS_RING_INJECT_PERF_EN
  logic [15:0]   o_stall_cycles;
`endif

  always #5 clk = ~clk;

  pos_ring_inject_ctrl #(
    .PARTICLE_ADDR_WIDTH(AW),
    .MAX_INFLIGHT       (TB_MAX),
    .INFLIGHT_WIDTH     (IW)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .i_start                   (i_start),
    .i_num_particles           (i_num_particles),
    .i_gcid                    (i_gcid),
    .o_rd_en                   (o_rd_en),
    .o_rd_addr                 (o_rd_addr),
    .i_rd_data                 (i_rd_data),
    .i_slot_empty              (i_slot_empty),
    .i_dispatcher_back_pressure(i_dispatcher_back_pressure),
    .i_retire                  (i_retire),
    .o_local_offset_pkt        (o_local_offset_pkt),
    .o_local_gcid              (o_local_gcid),
    .o_local_valid             (o_local_valid),
    .o_inflight                (o_inflight),
    .o_busy                    (o_busy),
    .o_done                    (o_done)
`ifdef POS_RING_INJECT_PERF_EN
    ,
    .o_stall_cycles            (o_stall_cycles)
`endif
  );

  typedef struct packed {
    logic [OW-1:0] data;
    logic [GW-1:0] gcid;
  } exp_pkt_t;

  exp_pkt_t      exp_q[$];
  int            compared     = 0;
  int            mismatched   = 0;
  int            done_pending = 0;
  int            inj_count    = 0;
  logic [AW-1:0] cur_num      = '0;

  function automatic logic [OW-1:0] mem_word(input logic [AW-1:0] a);
    return {8'hA5, 1'b0, a, 8'h3C, 1'b0, ~a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cache read port: data valid exactly one cycle after the strobe.
  always @(posedge clk) i_rd_data <= o_rd_en ? mem_word(o_rd_addr) : '0;

  always @(negedge clk) begin
    exp_pkt_t e;
    if (!rst) begin
      if (o_local_valid) begin
        inj_count++;
        check("inject_queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("inject_data", 64'(o_local_offset_pkt), 64'(e.data));
          check("inject_gcid", 64'(o_local_gcid), 64'(e.gcid));
        end
      end
      if (o_done) begin
        check("done_expected", 64'(done_pending > 0), 64'd1);
        if (done_pending > 0) done_pending--;
      end
      if (o_rd_en) check("rd_addr_range", 64'(o_rd_addr < cur_num), 64'd1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_bcast(input logic [AW-1:0] n, input logic [GW-1:0] g);
    for (int a = 0; a < int'(n); a++) exp_q.push_back('{data: mem_word(AW'(a)), gcid: g});
    cur_num         = n;
    done_pending++;
    i_start         = 1'b1;
    i_num_particles = n;
    i_gcid          = g;
    @(posedge clk); #1;
    i_start         = 1'b0;
  endtask

  task automatic retire_pulse();
    i_retire = 1'b1;
    @(posedge clk); #1;
    i_retire = 1'b0;
  endtask

  task automatic wait_inflight(input int target, input int budget);
    int n = 0;
    while (int'(o_inflight) != target && n < budget) begin @(posedge clk); #1; n++; end
    check("wait_inflight", 64'(o_inflight), 64'(target));
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_pending != 0 && n < budget) begin @(posedge clk); #1; n++; end
    check("wait_done", 64'(done_pending), 64'd0);
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    mismatched++;
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; i_start = 1'b0; i_num_particles = '0; i_gcid = '0;
    i_slot_empty = 1'b1; i_dispatcher_back_pressure = 1'b0; i_retire = 1'b0;
    cyc(3);
    check("rst_ctrl_outputs", 64'({o_rd_en, o_rd_addr, o_local_valid, o_inflight, o_busy, o_done}), 64'd0);
    check("rst_pkt",  64'(o_local_offset_pkt), 64'd0);
    check("rst_gcid", 64'(o_local_gcid), 64'd0);
    rst = 1'b0;
    cyc(2);

    // Basic stream of 4, latency of first read and first injection.
    start_bcast(7'd4, 15'h1234);
    @(negedge clk);
    check("c1_rd_en", 64'(o_rd_en), 64'd1);
    check("c1_rd_addr", 64'(o_rd_addr), 64'd0);
    check("c1_busy", 64'(o_busy), 64'd1);
    @(posedge clk); #1; @(negedge clk);
    check("c2_rd_en", 64'(o_rd_en), 64'd0);
    check("c2_valid", 64'(o_local_valid), 64'd0);
    @(posedge clk); #1; @(negedge clk);
    check("c3_valid", 64'(o_local_valid), 64'd1);
    @(posedge clk); #1;
    wait_inflight(4, 60);
    check("t1_drain_busy", 64'(o_busy), 64'd1);
    repeat (4) retire_pulse();
    wait_done(40);
    check("t1_inflight_zero", 64'(o_inflight), 64'd0);
    check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

    // Back pressure over cycles 3..10 holds the buffer and blocks injection.
    start_bcast(7'd3, 15'h2BCD);
    for (int c = 2; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 3) i_dispatcher_back_pressure = 1'b1;
      if (c >= 3) begin
        @(negedge clk);
        check("bp_no_inject", 64'(o_local_valid), 64'd0);
        check("bp_buf_held", 64'(o_local_offset_pkt), 64'(mem_word(7'd0)));
      end
    end
    @(posedge clk); #1;
    i_dispatcher_back_pressure = 1'b0;
    wait_inflight(3, 60);
    repeat (3) retire_pulse();
    wait_done(40);

    // Credit exhaustion: 6 particles, 4 credits, each retire releases one.
    base = inj_count;
    start_bcast(7'd6, 15'h3001);
    wait_inflight(TB_MAX, 60);
    cyc(6);
    check("credit_stop_count", 64'(inj_count - base), 64'd4);
    check("credit_stop_valid", 64'(o_local_valid), 64'd0);
    for (int k = 0; k < 2; k++) begin
      retire_pulse();
      cyc(4);
      check("credit_release_one", 64'(inj_count - base), 64'(5 + k));
      check("credit_inflight", 64'(o_inflight), 64'(TB_MAX));
    end
    check("credit_drain_busy", 64'(o_busy), 64'd1);
    repeat (4) retire_pulse();
    wait_done(40);

    // Inject and retire in the same cycle with one packet outstanding.
    start_bcast(7'd2, 15'h4444);
    cyc(3);
    check("same_pre_inflight", 64'(o_inflight), 64'd1);
    cyc(1);
    i_retire = 1'b1;
    @(negedge clk);
    check("same_inject", 64'(o_local_valid), 64'd1);
    @(posedge clk); #1;
    i_retire = 1'b0;
    check("same_post_inflight", 64'(o_inflight), 64'd1);
    retire_pulse();
    wait_done(20);
    retire_pulse();
    cyc(1);
    check("retire_at_zero", 64'(o_inflight), 64'd0);
    check("idle_busy", 64'(o_busy), 64'd0);

    // Zero particles: done in cycle 1, no reads.
    start_bcast(7'd0, 15'h5555);
    @(negedge clk);
    check("num0_done_c1", 64'(o_done), 64'd1);
    check("num0_no_rd", 64'(o_rd_en), 64'd0);
    @(posedge clk); #1;
    check("num0_done_once", 64'(o_done), 64'd0);
    check("num0_idle", 64'(o_busy), 64'd0);
    wait_done(5);

    // A second start during STREAM is ignored (gcid and count stay from the first).
    start_bcast(7'd2, 15'h6066);
    i_start = 1'b1; i_num_particles = 7'd5; i_gcid = 15'h7777;
    @(posedge clk); #1;
    i_start = 1'b0;
    wait_inflight(2, 40);
    cyc(4);
    check("ignored_start_inflight", 64'(o_inflight), 64'd2);
    repeat (2) retire_pulse();
    wait_done(20);

    // Reset in the middle of STREAM clears every output immediately.
    start_bcast(7'd4, 15'h0ABC);
    cyc(4);
    rst = 1'b1;
    #2;
    check("midrst_ctrl_outputs", 64'({o_rd_en, o_rd_addr, o_local_valid, o_inflight, o_busy, o_done}), 64'd0);
    check("midrst_pkt", 64'(o_local_offset_pkt), 64'd0);
    check("midrst_gcid", 64'(o_local_gcid), 64'd0);
    exp_q.delete();
    done_pending = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1);
    start_bcast(7'd2, 15'h1E1E);
    wait_inflight(2, 40);
    repeat (2) retire_pulse();
    wait_done(20);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_inflight", 64'(o_inflight), 64'd0);

    summary();
    $finish;
  end

endmodule
